sme_pkt_feeder: RTL
===================

// Module: sme_pkt_feeder
// PURPOSE
// Initiator side of the Pigasus SME wrapper interface. Takes a packet descriptor (address, length).
// Reads the packet from packet SRAM and streams it on an AXI-Stream master with tempty/tlast.
// Collects the wrapper's match results one by one, acknowledging each with match_release.
// Reports every rule ID, then a done record, on a result stream to the core.
// PARAMETERS
// BYTE_COUNT   16  stream width in bytes; power of 2
// ADDR_WIDTH   16  byte address width of packet SRAM
// LEN_WIDTH    16  packet length field width (bytes)
// DRAIN_CYCLES 32  idle cycles with no match_valid after tlast before a packet is declared done
// PORTS
// clk            in   1                      single clock
// rst            in   1                      synchronous, active-high reset
// cmd_valid      in   1                      descriptor valid
// cmd_ready      out  1                      descriptor accepted when valid&ready
// cmd_addr       in   ADDR_WIDTH             packet start byte address; low log2(BYTE_COUNT) bits ignored (aligned)
// cmd_len        in   LEN_WIDTH              packet length in bytes
// mem_rd_en      out  1                      SRAM read strobe
// mem_rd_addr    out  ADDR_WIDTH-log2(BC)    SRAM word address
// mem_rd_data    in   BYTE_COUNT*8           read data, fixed 1-cycle latency after mem_rd_en
// m_axis_tdata   out  BYTE_COUNT*8           packet word, byte 0 in [7:0]
// m_axis_tempty  out  log2(BYTE_COUNT)       unused trailing bytes; meaningful on tlast only
// m_axis_tvalid  out  1                      stream valid
// m_axis_tlast   out  1                      final beat
// m_axis_tready  in   1                      stream ready
// reload         out  1                      one-cycle pulse that clears SME state before each packet
// match_valid    in   1                      SME has an unreleased match
// match_rule_ID  in   16                     rule ID of the presented match
// match_release  out  1                      one-cycle pulse acknowledging the presented match
// res_valid      out  1                      result record valid
// res_ready      in   1                      result record accepted
// res_rule_id    out  16                     rule ID, or {8'd0, match_count} when res_last=1
// res_last       out  1                      done record for the current packet
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; word FIFO, counters and holdoff cleared. Mid-packet reset aborts the packet; no done record.
// - FSM: IDLE -> RELOAD -> STREAM -> DRAIN -> DONE -> IDLE.
// - IDLE: cmd_ready=1. On cmd_valid, latch addr/len and go to RELOAD. cmd_len=0: go straight to DONE, no reload, no stream.
// - RELOAD: reload=1 for exactly one cycle; match_count=0; go to STREAM.
// - STREAM, words: nwords = ceil(len/BYTE_COUNT).
//   - 4-entry word FIFO. Issue mem_rd_en while reads_issued<nwords and (occupancy+inflight)<4.
//   - mem_rd_addr increments by 1 per read.
// - STREAM, tvalid: m_axis_tvalid = FIFO non-empty.
//   - The SME derives SOP from the tvalid rising edge, so once the first beat is shown, tvalid stays high until tlast is accepted.
//   - The FIFO depth plus continuous reads guarantee this; a bench assertion checks no bubble.
// - STREAM, tlast/tempty: m_axis_tlast on beat nwords-1. tempty = (BYTE_COUNT - len%BYTE_COUNT) % BYTE_COUNT on that beat, 0 otherwise.
// - STREAM exit: tlast&tready -> DRAIN. tvalid is low >= 1 cycle between packets (via DRAIN/DONE/IDLE/RELOAD).
// - Match collection (STREAM and DRAIN):
//   - When match_valid & holdoff==0, drive res_valid=1, res_rule_id=match_rule_ID, res_last=0.
//   - On res_valid&res_ready: pulse match_release for 1 cycle, match_count+=1 (saturating at 255), holdoff=2.
//   - holdoff counts down 1 per cycle. It covers the SME's 2-cycle registered mask/valid update, so a match is never reported twice.
// - DRAIN: counter loads DRAIN_CYCLES on entry and whenever match_valid=1 or a result is pending; otherwise decrements.
//   - At 0 with no pending result -> DONE.
// - DONE: res_valid=1, res_last=1, res_rule_id={8'd0,match_count}. Held until res_ready, then IDLE.
// - res_valid, once asserted, holds with stable data until accepted.
// - Simultaneous events: cmd_valid during a busy packet is ignored (cmd_ready=0); tready stall during match handshake is independent.
// - Throughput: 1 beat/cycle after a 2-cycle start (reload + first read latency).
// TESTING
// 1. len=40, BC=16, tready=1, no matches -> reload pulse; 3 beats, tlast on beat 2, tempty=8; after 32 idle cycles, done record with res_rule_id=0.
// 2. len=32 -> 2 beats, tempty=0 on tlast; len=0 -> no reload, no beats, done record with count 0 immediately.
// 3. Random tready (50%) on len=100 -> tvalid never drops between first beat and tlast; data matches SRAM; tempty=12.
// 4. SME model presents rule IDs 5, 9, 300 sequentially -> three records 5, 9, 300, each followed by one match_release pulse. No duplicates despite 2-cycle mask latency. Done record count=3.
// 5. res_ready held low 50 cycles while match pending -> res_valid and res_rule_id stable, no release, DRAIN does not expire.
// 6. rst asserted mid-STREAM -> next cycle all outputs 0, FSM IDLE. A new cmd then streams correctly from its own address.

Source files
------------

// File: rtl/sme_pkt_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sme_pkt_feeder
// Brief    : Streams packets from SRAM to the SME and reports its match results.
// Revision : 1.0
// ============================================================================
module sme_pkt_feeder #(
  parameter int BYTE_COUNT   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                    cmd_addr,
  input  logic [LEN_WIDTH-1:0]                     cmd_len,
  output logic                                     mem_rd_en,
  output logic [ADDR_WIDTH-$clog2(BYTE_COUNT)-1:0] mem_rd_addr,
  input  logic [BYTE_COUNT*8-1:0]                  mem_rd_data,
  output logic [BYTE_COUNT*8-1:0]                  m_axis_tdata,
  output logic [$clog2(BYTE_COUNT)-1:0]            m_axis_tempty,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic                                     reload,
  input  logic                                     match_valid,
  input  logic [15:0]                              match_rule_ID,
  output logic                                     match_release,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [15:0]                              res_rule_id,
  output logic                                     res_last
);
  localparam int c_OW = $clog2(BYTE_COUNT);
  localparam int c_WA = ADDR_WIDTH - c_OW;
  localparam int c_NW = LEN_WIDTH - c_OW + 1;
  localparam int c_DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RELOAD = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [BYTE_COUNT*8-1:0] fifo_q [4];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              occ_q;
  logic                    rd_pend_q;
  logic [c_WA-1:0]         addr_q;
  logic [c_NW-1:0]         nwords_q, reads_q, beats_q;
  logic [c_OW-1:0]         tempty_q;
  logic [c_DW-1:0]         drain_q;
  logic [1:0]              holdoff_q;
  logic [7:0]              count_q;
  logic                    cmd_ready_q, reload_q, res_valid_q, res_last_q;
  logic [15:0]             res_id_q;

  logic                    rd_fire, pop, beat_last, res_hs, take_match;
  logic [LEN_WIDTH:0]      len_sum;
  logic [c_NW-1:0]         len_words;
  logic                    unused_bits;

  assign len_sum     = {1'b0, cmd_len} + (LEN_WIDTH+1)'(BYTE_COUNT - 1);
  assign len_words   = len_sum[LEN_WIDTH:c_OW];
  assign unused_bits = ^{cmd_addr[c_OW-1:0], len_sum[c_OW-1:0]};

  // Reads may start in RELOAD so the first beat appears two cycles after reload.
  assign rd_fire = ((state_q == S_RELOAD) || (state_q == S_STREAM)) && (reads_q != nwords_q)
                   && (({1'b0, occ_q} + {3'b0, rd_pend_q}) < 4'd4);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign beat_last  = (beats_q == nwords_q - c_NW'(1));
  assign res_hs     = res_valid_q && res_ready;
  assign take_match = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && match_valid
                      && (holdoff_q == 2'd0) && !res_valid_q;

  assign mem_rd_en     = rd_fire;
  assign mem_rd_addr   = addr_q;
  assign m_axis_tvalid = (occ_q != 3'd0);
  assign m_axis_tlast  = m_axis_tvalid && beat_last;
  assign m_axis_tempty = m_axis_tlast ? tempty_q : '0;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_ptr_q] : '0;
  assign match_release = res_hs && !res_last_q;
  assign cmd_ready     = cmd_ready_q;
  assign reload        = reload_q;
  assign res_valid     = res_valid_q;
  assign res_last      = res_last_q;
  assign res_rule_id   = res_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rd_pend_q   <= 1'b0;
      addr_q      <= '0;
      nwords_q    <= '0;
      reads_q     <= '0;
      beats_q     <= '0;
      tempty_q    <= '0;
      drain_q     <= '0;
      holdoff_q   <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      reload_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      reload_q  <= 1'b0;
      rd_pend_q <= rd_fire;
      if (rd_fire) begin
        addr_q  <= addr_q + c_WA'(1);
        reads_q <= reads_q + c_NW'(1);
      end
      if (rd_pend_q) begin
        fifo_q[wr_ptr_q] <= mem_rd_data;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        beats_q  <= beats_q + c_NW'(1);
      end
      occ_q <= occ_q + {2'b0, rd_pend_q} - {2'b0, pop};

      // Holdoff masks the SME's stale match_valid while its release propagates.
      if (holdoff_q != 2'd0) holdoff_q <= holdoff_q - 2'd1;
      if (take_match) begin
        res_valid_q <= 1'b1;
        res_id_q    <= match_rule_ID;
      end
      if (res_hs) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
        if (!res_last_q) begin
          holdoff_q <= 2'd2;
          if (count_q != 8'hFF) count_q <= count_q + 8'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr[ADDR_WIDTH-1:c_OW];
            nwords_q    <= len_words;
            tempty_q    <= -cmd_len[c_OW-1:0];
            reads_q     <= '0;
            beats_q     <= '0;
            count_q     <= '0;
            if (cmd_len == '0) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
              res_last_q  <= 1'b1;
              res_id_q    <= '0;
            end else begin
              state_q  <= S_RELOAD;
              reload_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_RELOAD: state_q <= S_STREAM;
        S_STREAM: begin
          if (pop && beat_last) begin
            state_q <= S_DRAIN;
            drain_q <= c_DW'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          if (match_valid || res_valid_q) begin
            drain_q <= c_DW'(DRAIN_CYCLES);
          end else if (drain_q == '0) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
            res_last_q  <= 1'b1;
            res_id_q    <= {8'd0, count_q};
          end else begin
            drain_q <= drain_q - c_DW'(1);
          end
        end
        S_DONE: begin
          if (res_hs) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
